iiitb_fifo_arb_ctrl: RTL

Controller that shares the team's 16-deep x 8-bit synchronous FIFO between two producer channels and sequences its read side toward one consumer. Write side: round-robin arbiter with bounded burst ownership. Read side: issues FIFO reads and presents data through a valid/ready output. The block tracks occupancy internally and never uses the FIFO's full/empty outputs.

---
 rtl/iiitb_fifo_arb_ctrl_if.sv | 36 +++
 rtl/iiitb_fifo_arb_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/iiitb_fifo_arb_ctrl_if.sv
// Handshake bundle between the FIFO arbiter/controller, its two producers,
// the shared FIFO and the consumer.
interface iiitb_fifo_arb_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 5
);
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          fifo_write;
    logic [DW-1:0] fifo_wdata;
    logic          fifo_read;
    logic [DW-1:0] fifo_rdata;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [CW-1:0] occupancy;
    logic [1:0]    owner;

    // Controller side
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, fifo_rdata, out_ready,
        output req0_ready, req1_ready, fifo_write, fifo_wdata, fifo_read,
               out_valid, out_data, occupancy, owner
    );

    // Producer / FIFO / consumer side
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, fifo_rdata, out_ready,
        input  req0_ready, req1_ready, fifo_write, fifo_wdata, fifo_read,
               out_valid, out_data, occupancy, owner
    );
endinterface

// File: rtl/iiitb_fifo_arb_ctrl.sv
// Shares one 16x8 synchronous FIFO between two producers (round-robin with
// bounded bursts) and drains it toward a single valid/ready consumer.
module iiitb_fifo_arb_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 5,
    parameter int unsigned BURST = 4
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    iiitb_fifo_arb_ctrl_if.slave  bus
);
    localparam int unsigned BCW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_last_owner;
    logic           w_last_owner_nxt;
    logic [BCW-1:0] r_burst_cnt;
    logic [BCW-1:0] w_burst_cnt_nxt;
    logic [CW-1:0]  r_occ;
    logic           r_out_valid;

    logic           w_full;
    logic           w_empty;
    logic           w_ready0;
    logic           w_ready1;
    logic           w_beat;
    logic [DW-1:0]  w_wdata;
    logic           w_own_valid;
    logic           w_oth_valid;
    logic           w_release;
    logic           w_read;

    assign w_full  = (r_occ == CW'(DEPTH));
    assign w_empty = (r_occ == '0);

    // Arbiter state register
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
            r_burst_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
        end
    end

    // Next-state: a stalled grant (valid high, FIFO full) neither counts nor releases
    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        w_burst_cnt_nxt  = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    w_state_nxt = r_last_owner ? ST_GNT0 : ST_GNT1;
                end else if (bus.req0_valid) begin
                    w_state_nxt = ST_GNT0;
                end else if (bus.req1_valid) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (w_release) begin
                    w_last_owner_nxt = (r_state == ST_GNT1);
                    w_burst_cnt_nxt  = '0;
                    if (w_oth_valid) begin
                        w_state_nxt = (r_state == ST_GNT0) ? ST_GNT1 : ST_GNT0;
                    end else if (w_own_valid) begin
                        w_state_nxt = r_state;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_beat) begin
                    w_burst_cnt_nxt = r_burst_cnt + BCW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register; all strobes forced low in reset
    always_comb begin
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_beat      = 1'b0;
        w_wdata     = '0;
        w_own_valid = 1'b0;
        w_oth_valid = 1'b0;
        case (r_state)
            ST_GNT0: begin
                w_own_valid = bus.req0_valid;
                w_oth_valid = bus.req1_valid;
                w_ready0    = RSTn & ~w_full;
                w_beat      = bus.req0_valid & w_ready0;
                w_wdata     = bus.req0_data;
            end
            ST_GNT1: begin
                w_own_valid = bus.req1_valid;
                w_oth_valid = bus.req0_valid;
                w_ready1    = RSTn & ~w_full;
                w_beat      = bus.req1_valid & w_ready1;
                w_wdata     = bus.req1_data;
            end
            default: ;
        endcase
        w_release = ~w_own_valid | (w_beat & (r_burst_cnt == BCW'(BURST - 1)));
        w_read    = RSTn & ~w_empty & (~r_out_valid | bus.out_ready);
    end

    // Occupancy and consumer-side valid
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_occ       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_occ <= r_occ + CW'(w_beat) - CW'(w_read);
            if (w_read) begin
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.fifo_write = w_beat;
    assign bus.fifo_wdata = w_wdata;
    assign bus.fifo_read  = w_read;
    assign bus.out_valid  = RSTn & r_out_valid;
    assign bus.out_data   = bus.fifo_rdata;
    assign bus.occupancy  = RSTn ? r_occ : '0;
    assign bus.owner      = RSTn ? r_state : ST_IDLE;

endmodule
